// File: rtl/prog_mem_arbiter.sv
// prog_mem_arbiter: shares the 1024x18 synchronous program memory between the
// CPU fetch path and a debug/loader port. At most one access is granted per
// cycle, and the one-cycle-latency read data is routed back to whoever issued it.
//
// Ports
//   i_clk, i_rst        clock, asynchronous active-high reset
//   i_cpu_req/addr      fetch request and address
//   o_cpu_gnt           fetch accepted this cycle (combinational)
//   o_cpu_valid/ir      fetched word (bypass when valid, else last word held)
//   i_dbg_hold          blocks all CPU grants while high
//   i_dbg_req/we/addr/wdata  debug read/write request
//   o_dbg_ack           debug access accepted this cycle (combinational)
//   o_dbg_rvalid/rdata  debug read word (bypass when valid, else last word held)
//   o_mem_addr/we/wdata memory request, driven combinationally by the winner
//   i_mem_rdata         memory read data, one cycle after the address
//   o_stall_cnt         saturating count of denied CPU request cycles
module prog_mem_arbiter #(
   parameter  int unsigned STARVE_MAX = 4,
   localparam int unsigned AW         = 10,
   localparam int unsigned DW         = 18,
   localparam int unsigned SW         = 4,
   localparam int unsigned CW         = 16
) (
   input  logic          i_clk,
   input  logic          i_rst,
   input  logic          i_cpu_req,
   input  logic [AW-1:0] i_cpu_addr,
   output logic          o_cpu_gnt,
   output logic          o_cpu_valid,
   output logic [DW-1:0] o_cpu_ir,
   input  logic          i_dbg_hold,
   input  logic          i_dbg_req,
   input  logic          i_dbg_we,
   input  logic [AW-1:0] i_dbg_addr,
   input  logic [DW-1:0] i_dbg_wdata,
   output logic          o_dbg_ack,
   output logic          o_dbg_rvalid,
   output logic [DW-1:0] o_dbg_rdata,
   output logic [AW-1:0] o_mem_addr,
   output logic          o_mem_we,
   output logic [DW-1:0] o_mem_wdata,
   input  logic [DW-1:0] i_mem_rdata,
   output logic [CW-1:0] o_stall_cnt
);

   // Owner of the read data arriving in the current cycle.
   typedef enum logic [1:0] {
      OWN_NONE = 2'd0,
      OWN_CPU  = 2'd1,
      OWN_DBG  = 2'd2
   } own_e;

   own_e          r_rd_own;
   own_e          w_rd_own_nxt;
   logic [SW-1:0] r_starve;
   logic [SW-1:0] w_starve_nxt;
   logic [CW-1:0] r_stall_cnt;
   logic [CW-1:0] w_stall_nxt;
   logic [DW-1:0] r_cpu_hold;
   logic [DW-1:0] r_dbg_hold;
   logic          w_cpu_win;
   logic          w_dbg_win;
   logic          w_starved;

   assign w_starved = (r_starve == SW'(STARVE_MAX));

   // State register: read-return owner, starvation and stall counters.
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_rd_own    <= OWN_NONE;
         r_starve    <= '0;
         r_stall_cnt <= '0;
      end else begin
         r_rd_own    <= w_rd_own_nxt;
         r_starve    <= w_starve_nxt;
         r_stall_cnt <= w_stall_nxt;
      end
   end

   // Grant priority, next owner tag and counter updates.
   always_comb begin
      w_cpu_win    = 1'b0;
      w_dbg_win    = 1'b0;
      w_rd_own_nxt = OWN_NONE;
      w_starve_nxt = '0;
      w_stall_nxt  = r_stall_cnt;

      // Grants are gated by reset so nothing reaches memory while it is held.
      if (!i_rst) begin
         if (i_dbg_req && (i_dbg_hold || w_starved)) begin
            w_dbg_win = 1'b1;
         end else if (i_cpu_req && !i_dbg_hold) begin
            w_cpu_win = 1'b1;
         end else if (i_dbg_req) begin
            w_dbg_win = 1'b1;
         end
      end

      // Debug writes complete at the grant edge and return nothing.
      if (w_cpu_win) begin
         w_rd_own_nxt = OWN_CPU;
      end else if (w_dbg_win && !i_dbg_we) begin
         w_rd_own_nxt = OWN_DBG;
      end

      // Starvation counts only consecutive denied debug cycles.
      if (i_dbg_req && !w_dbg_win) begin
         w_starve_nxt = w_starved ? r_starve : r_starve + SW'(1);
      end

      if (i_cpu_req && !w_cpu_win && (r_stall_cnt != '1)) begin
         w_stall_nxt = r_stall_cnt + CW'(1);
      end
   end

   // Hold registers capture the returned word at the edge closing its valid cycle.
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_cpu_hold <= '0;
         r_dbg_hold <= '0;
      end else begin
         if (r_rd_own == OWN_CPU) r_cpu_hold <= i_mem_rdata;
         if (r_rd_own == OWN_DBG) r_dbg_hold <= i_mem_rdata;
      end
   end

   assign o_cpu_gnt    = w_cpu_win;
   assign o_dbg_ack    = w_dbg_win;
   assign o_mem_addr   = w_dbg_win ? i_dbg_addr : i_cpu_addr;
   assign o_mem_we     = w_dbg_win & i_dbg_we;
   assign o_mem_wdata  = i_dbg_wdata;
   assign o_cpu_valid  = (r_rd_own == OWN_CPU);
   assign o_dbg_rvalid = (r_rd_own == OWN_DBG);
   assign o_cpu_ir     = o_cpu_valid  ? i_mem_rdata : r_cpu_hold;
   assign o_dbg_rdata  = o_dbg_rvalid ? i_mem_rdata : r_dbg_hold;
   assign o_stall_cnt  = r_stall_cnt;

endmodule

// File: tb/tb_prog_mem_arbiter.sv
// Testbench for prog_mem_arbiter: per-cycle vector table with a read-return
// scoreboard and a behavioural 1024x18 synchronous memory.
module tb_prog_mem_arbiter;

   logic        clk = 1'b0;
   logic        rst;
   logic        cpu_req, cpu_gnt, cpu_valid;
   logic [9:0]  cpu_addr;
   logic [17:0] cpu_ir;
   logic        dbg_hold, dbg_req, dbg_we, dbg_ack, dbg_rvalid;
   logic [9:0]  dbg_addr;
   logic [17:0] dbg_wdata, dbg_rdata;
   logic [9:0]  mem_addr;
   logic        mem_we;
   logic [17:0] mem_wdata, mem_rdata;
   logic [15:0] stall_cnt;

   always #5 clk = ~clk;

   prog_mem_arbiter #(.STARVE_MAX(4)) dut (
      .i_clk(clk), .i_rst(rst),
      .i_cpu_req(cpu_req), .i_cpu_addr(cpu_addr), .o_cpu_gnt(cpu_gnt),
      .o_cpu_valid(cpu_valid), .o_cpu_ir(cpu_ir),
      .i_dbg_hold(dbg_hold), .i_dbg_req(dbg_req), .i_dbg_we(dbg_we),
      .i_dbg_addr(dbg_addr), .i_dbg_wdata(dbg_wdata), .o_dbg_ack(dbg_ack),
      .o_dbg_rvalid(dbg_rvalid), .o_dbg_rdata(dbg_rdata),
      .o_mem_addr(mem_addr), .o_mem_we(mem_we), .o_mem_wdata(mem_wdata),
      .i_mem_rdata(mem_rdata), .o_stall_cnt(stall_cnt)
   );

   // Behavioural synchronous program memory.
   logic [17:0] mem [1024];
   always @(posedge clk) begin
      if (mem_we) mem[mem_addr] <= mem_wdata;
      mem_rdata <= mem[mem_addr];
   end

   typedef struct {
      logic        rst;
      logic        hold;
      logic        creq;
      logic [9:0]  caddr;
      logic        dreq;
      logic        dwe;
      logic [9:0]  daddr;
      logic [17:0] dwd;
      logic        gnt;
      logic        ack;
   } vec_t;

   vec_t        vecs[$];
   logic [17:0] shadow [1024];
   logic [17:0] cpu_q[$];
   logic [17:0] dbg_q[$];
   logic        exp_cpu_v, exp_dbg_v;
   logic [17:0] exp_ir, exp_rd;
   logic [15:0] exp_stall;
   int          n_checks = 0;
   int          n_fail   = 0;

   function automatic vec_t mk(logic r, logic h, logic cr, logic [9:0] ca,
                               logic dr, logic dw, logic [9:0] da,
                               logic [17:0] dd, logic g, logic a);
      vec_t v;
      v.rst = r; v.hold = h; v.creq = cr; v.caddr = ca; v.dreq = dr;
      v.dwe = dw; v.daddr = da; v.dwd = dd; v.gnt = g; v.ack = a;
      return v;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic clear_model();
      exp_cpu_v = 1'b0;
      exp_dbg_v = 1'b0;
      exp_ir    = '0;
      exp_rd    = '0;
      exp_stall = '0;
      cpu_q.delete();
      dbg_q.delete();
   endtask

   // One cycle: drive after the edge, check at the falling edge, update the model.
   task automatic step(input vec_t v);
      @(posedge clk);
      #1;
      rst = v.rst; dbg_hold = v.hold; cpu_req = v.creq; cpu_addr = v.caddr;
      dbg_req = v.dreq; dbg_we = v.dwe; dbg_addr = v.daddr; dbg_wdata = v.dwd;
      @(negedge clk);
      if (v.rst) begin
         chk("rst_cpu_gnt",    32'(cpu_gnt),    32'd0);
         chk("rst_dbg_ack",    32'(dbg_ack),    32'd0);
         chk("rst_cpu_valid",  32'(cpu_valid),  32'd0);
         chk("rst_dbg_rvalid", 32'(dbg_rvalid), 32'd0);
         chk("rst_cpu_ir",     32'(cpu_ir),     32'd0);
         chk("rst_dbg_rdata",  32'(dbg_rdata),  32'd0);
         chk("rst_mem_we",     32'(mem_we),     32'd0);
         chk("rst_stall_cnt",  32'(stall_cnt),  32'd0);
         clear_model();
      end else begin
         chk("cpu_valid", 32'(cpu_valid), 32'(exp_cpu_v));
         if (exp_cpu_v && cpu_q.size() > 0) exp_ir = cpu_q.pop_front();
         chk("cpu_ir", 32'(cpu_ir), 32'(exp_ir));
         chk("dbg_rvalid", 32'(dbg_rvalid), 32'(exp_dbg_v));
         if (exp_dbg_v && dbg_q.size() > 0) exp_rd = dbg_q.pop_front();
         chk("dbg_rdata", 32'(dbg_rdata), 32'(exp_rd));
         chk("stall_cnt", 32'(stall_cnt), 32'(exp_stall));
         chk("cpu_gnt", 32'(cpu_gnt), 32'(v.gnt));
         chk("dbg_ack", 32'(dbg_ack), 32'(v.ack));
         chk("mem_we", 32'(mem_we), 32'(v.ack & v.dwe));
         chk("mem_addr", 32'(mem_addr), 32'(v.ack ? v.daddr : v.caddr));
         if (v.ack && v.dwe) chk("mem_wdata", 32'(mem_wdata), 32'(v.dwd));

         exp_cpu_v = v.gnt;
         exp_dbg_v = v.ack & !v.dwe;
         if (v.gnt) cpu_q.push_back(shadow[v.caddr]);
         if (v.ack && !v.dwe) dbg_q.push_back(shadow[v.daddr]);
         if (v.ack && v.dwe) shadow[v.daddr] = v.dwd;
         if (v.creq && !v.gnt && exp_stall != 16'hFFFF) exp_stall = exp_stall + 16'd1;
      end
   endtask

   initial begin
      vec_t hv;
      rst = 1'b1; cpu_req = 1'b0; cpu_addr = '0; dbg_hold = 1'b0; dbg_req = 1'b0;
      dbg_we = 1'b0; dbg_addr = '0; dbg_wdata = '0;
      for (int i = 0; i < 1024; i++) begin
         mem[i]    = 18'(32'h30001 + i);
         shadow[i] = 18'(32'h30001 + i);
      end
      clear_model();

      // Reset with a fetch pending, then CPU-only fetches and hold behaviour.
      vecs.push_back(mk(1,0,1,10'd0,  0,0,10'd0,  18'h0,     0,0));
      vecs.push_back(mk(1,0,1,10'd0,  0,0,10'd0,  18'h0,     0,0));
      vecs.push_back(mk(0,0,1,10'd0,  0,0,10'd0,  18'h0,     1,0));
      vecs.push_back(mk(0,0,1,10'd1,  0,0,10'd0,  18'h0,     1,0));
      vecs.push_back(mk(0,0,1,10'd2,  0,0,10'd0,  18'h0,     1,0));
      vecs.push_back(mk(0,0,0,10'd2,  0,0,10'd0,  18'h0,     0,0));
      vecs.push_back(mk(0,0,0,10'd2,  0,0,10'd0,  18'h0,     0,0));
      // Debug write then read of the top address.
      vecs.push_back(mk(0,0,0,10'd0,  1,1,10'h3FF,18'h2ABCD, 0,1));
      vecs.push_back(mk(0,0,0,10'd0,  1,0,10'h3FF,18'h0,     0,1));
      vecs.push_back(mk(0,0,0,10'd0,  0,0,10'h3FF,18'h0,     0,0));
      vecs.push_back(mk(0,0,0,10'd0,  0,0,10'h3FF,18'h0,     0,0));
      // Starvation: four CPU grants, debug on the fifth, CPU resumes.
      for (int i = 0; i < 4; i++)
         vecs.push_back(mk(0,0,1,10'(10+i),1,0,10'h3FF,18'h0, 1,0));
      vecs.push_back(mk(0,0,1,10'd14, 1,0,10'h3FF,18'h0,     0,1));
      vecs.push_back(mk(0,0,1,10'd14, 1,0,10'd5,  18'h0,     1,0));
      vecs.push_back(mk(0,0,1,10'd15, 0,0,10'd5,  18'h0,     1,0));
      // Dropping the debug request clears the starvation count.
      for (int i = 0; i < 3; i++)
         vecs.push_back(mk(0,0,1,10'(20+i),1,0,10'd6,18'h0,   1,0));
      vecs.push_back(mk(0,0,1,10'd23, 0,0,10'd6,  18'h0,     1,0));
      for (int i = 0; i < 4; i++)
         vecs.push_back(mk(0,0,1,10'(24+i),1,0,10'd6,18'h0,   1,0));
      vecs.push_back(mk(0,0,1,10'd28, 1,0,10'd6,  18'h0,     0,1));
      vecs.push_back(mk(0,0,0,10'd28, 0,0,10'd6,  18'h0,     0,0));
      // DBG_HOLD: debug wins every cycle, CPU stalls accumulate.
      vecs.push_back(mk(0,1,1,10'd30, 1,1,10'd20, 18'h01234, 0,1));
      vecs.push_back(mk(0,1,1,10'd30, 1,0,10'd20, 18'h0,     0,1));
      vecs.push_back(mk(0,1,1,10'd30, 1,0,10'd21, 18'h0,     0,1));
      vecs.push_back(mk(0,1,1,10'd30, 0,0,10'd21, 18'h0,     0,0));
      vecs.push_back(mk(0,0,0,10'd30, 0,0,10'd21, 18'h0,     0,0));
      // CPU fetch of a word written in the previous cycle.
      vecs.push_back(mk(0,0,0,10'd3,  1,1,10'd3,  18'h15555, 0,1));
      vecs.push_back(mk(0,0,1,10'd3,  0,0,10'd3,  18'h0,     1,0));
      vecs.push_back(mk(0,0,0,10'd3,  0,0,10'd3,  18'h0,     0,0));
      // Reset while a fetch is outstanding: its valid pulse is suppressed.
      vecs.push_back(mk(0,0,1,10'd0,  0,0,10'd0,  18'h0,     1,0));
      vecs.push_back(mk(1,0,1,10'd0,  0,0,10'd0,  18'h0,     0,0));
      vecs.push_back(mk(1,0,1,10'd0,  0,0,10'd0,  18'h0,     0,0));
      vecs.push_back(mk(0,0,1,10'd1,  0,0,10'd0,  18'h0,     1,0));
      vecs.push_back(mk(0,0,0,10'd1,  0,0,10'd0,  18'h0,     0,0));
      vecs.push_back(mk(1,0,0,10'd0,  0,0,10'd0,  18'h0,     0,0));

      foreach (vecs[i]) step(vecs[i]);

      // STALL_CNT saturation under a long DBG_HOLD.
      hv = mk(0,1,1,10'd7, 0,0,10'd0, 18'h0, 0,0);
      for (int i = 0; i < 65540; i++) step(hv);
      chk("stall_saturated", 32'(stall_cnt), 32'h0000FFFF);
      step(mk(0,0,0,10'd7, 0,0,10'd0, 18'h0, 0,0));

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
